// File: rtl/avcfg_pkg.sv
// avalon_cfg_master shared types: FSM states, error codes, slave register map.
// Imported by avcfg_watchdog and avalon_cfg_master.
package avcfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_VER,
        ST_RD_WAIT,
        ST_WR_NUMPKTS,
        ST_WR_PKTLEN,
        ST_WR_PAYLOAD,
        ST_WR_SCRATCH,
        ST_RD_SCRATCH,
        ST_WR_START,
        ST_FINISH,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_VERSION = 2'd1,
        ERR_SCRATCH = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    localparam logic [7:0] REG_NUMPKTS   = 8'd0;
    localparam logic [7:0] REG_START     = 8'd1;
    localparam logic [7:0] REG_STOP      = 8'd2;
    localparam logic [7:0] REG_PKTLENGTH = 8'd3;
    localparam logic [7:0] REG_PAYLOAD   = 8'd4;
    localparam logic [7:0] REG_VERSION   = 8'd5;
    localparam logic [7:0] REG_SCRATCH   = 8'd6;

    localparam logic [7:0] SCRATCH_PATTERN = 8'hA5;
    localparam logic [7:0] START_CMD       = 8'h01;

endpackage

// File: rtl/avcfg_watchdog.sv
// Stall watchdog: counts consecutive stalled request cycles since clr_i.
// Ports: clk_i, reset_i, clr_i (request issued), en_i (stalled), expired_o.
module avcfg_watchdog
    import avcfg_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // High during the TIMEOUT-th stalled cycle, so the caller can
    // drop the request on that edge instead of one cycle later.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/avalon_cfg_master.sv
// Avalon-MM master that programs the 8-bit register slave on a go pulse.
// Ports: clk/reset, go + cfg_* in, Avalon master bus, busy/done/error/err_code.
// Option: define AVCFG_SCRATCH_CHECK_EN to add the SCRATCH write/readback check.
module avalon_cfg_master
    import avcfg_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                RD_LAT      = 1,
    parameter int                TIMEOUT     = 64,
    parameter logic [DATA_W-1:0] EXP_VERSION = 'h12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] cfg_numpkts,
    input  logic [DATA_W-1:0] cfg_pktlength,
    input  logic [DATA_W-1:0] cfg_payload,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    err_code_e         err_code_q, err_code_d;
    logic [DATA_W-1:0] numpkts_q, numpkts_d;
    logic [DATA_W-1:0] pktlen_q, pktlen_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [1:0]        lat_q, lat_d;

    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;

    logic              op_go;
    logic              op_rd;
    logic [7:0]        op_addr;
    logic [DATA_W-1:0] op_data;
    state_e            op_nxt;

    logic              rd_check;
    logic [DATA_W-1:0] rd_exp;
    err_code_e         rd_code;
    state_e            rd_nxt;

    logic              fin;
    logic              fail;
    err_code_e         fail_code;

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    avcfg_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk_i     (clk),
        .reset_i   (reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        read_d      = read_q;
        write_d     = write_q;
        writedata_d = writedata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_code_d  = err_code_q;
        numpkts_d   = numpkts_q;
        pktlen_d    = pktlen_q;
        payload_d   = payload_q;
        lat_d       = lat_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        op_go       = 1'b0;
        op_rd       = 1'b0;
        op_addr     = '0;
        op_data     = '0;
        op_nxt      = ST_IDLE;
        rd_check    = 1'b0;
        fin         = 1'b0;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        // The address stays put after a read is accepted, so it tells
        // the data phase which register it is checking.
        if (address_q == ADDR_W'(REG_VERSION)) begin
            rd_exp  = EXP_VERSION;
            rd_code = ERR_VERSION;
            rd_nxt  = ST_WR_NUMPKTS;
        end else begin
            rd_exp  = DATA_W'(SCRATCH_PATTERN);
            rd_code = ERR_SCRATCH;
            rd_nxt  = ST_WR_START;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    numpkts_d  = cfg_numpkts;
                    pktlen_d   = cfg_pktlength;
                    payload_d  = cfg_payload;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_RD_VER;
                end
            end
            ST_RD_VER: begin
                op_go   = 1'b1;
                op_rd   = 1'b1;
                op_addr = REG_VERSION;
            end
            ST_WR_NUMPKTS: begin
                op_go   = 1'b1;
                op_addr = REG_NUMPKTS;
                op_data = numpkts_q;
                op_nxt  = ST_WR_PKTLEN;
            end
            ST_WR_PKTLEN: begin
                op_go   = 1'b1;
                op_addr = REG_PKTLENGTH;
                op_data = pktlen_q;
                op_nxt  = ST_WR_PAYLOAD;
            end
            ST_WR_PAYLOAD: begin
                op_go   = 1'b1;
                op_addr = REG_PAYLOAD;
                op_data = payload_q;
`ifdef AVCFG_SCRATCH_CHECK_EN
                op_nxt  = ST_WR_SCRATCH;
`else
                op_nxt  = ST_WR_START;
`endif
            end
`ifdef AVCFG_SCRATCH_CHECK_EN
            ST_WR_SCRATCH: begin
                op_go   = 1'b1;
                op_addr = REG_SCRATCH;
                op_data = DATA_W'(SCRATCH_PATTERN);
                op_nxt  = ST_RD_SCRATCH;
            end
            ST_RD_SCRATCH: begin
                op_go   = 1'b1;
                op_rd   = 1'b1;
                op_addr = REG_SCRATCH;
            end
`endif
            ST_WR_START: begin
                op_go   = 1'b1;
                op_addr = REG_START;
                op_data = DATA_W'(START_CMD);
                op_nxt  = ST_FINISH;
            end
            ST_RD_WAIT: begin
                if (lat_q == RD_LAT_C) begin
                    rd_check = 1'b1;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_FINISH, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared request phase: issue from an idle bus, hold while
        // stalled, release on acceptance or watchdog expiry.
        if (op_go) begin
            if (!(read_q || write_q)) begin
                address_d   = ADDR_W'(op_addr);
                writedata_d = op_data;
                read_d      = op_rd;
                write_d     = !op_rd;
                wd_clr      = 1'b1;
            end else if (!waitrequest) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (op_rd) begin
                    if (RD_LAT == 0) begin
                        rd_check = 1'b1;
                    end else begin
                        state_d = ST_RD_WAIT;
                        lat_d   = 2'd1;
                    end
                end else if (op_nxt == ST_FINISH) begin
                    fin = 1'b1;
                end else begin
                    state_d = op_nxt;
                end
            end else begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
        end

        if (rd_check) begin
            if (readdata != rd_exp) begin
                fail      = 1'b1;
                fail_code = rd_code;
            end else begin
                state_d = rd_nxt;
            end
        end

        if (fin) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end

        if (fail) begin
            state_d    = ST_ERR;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = fail_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            address_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            writedata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            numpkts_q   <= '0;
            pktlen_q    <= '0;
            payload_q   <= '0;
            lat_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            read_q      <= read_d;
            write_q     <= write_d;
            writedata_q <= writedata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            numpkts_q   <= numpkts_d;
            pktlen_q    <= pktlen_d;
            payload_q   <= payload_d;
            lat_q       <= lat_d;
        end
    end

    assign address   = address_q;
    assign read      = read_q;
    assign write     = write_q;
    assign writedata = writedata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_avalon_cfg_master.sv
// Bench for avalon_cfg_master: slave model, transfer scoreboard, vector table.
// Follows AVCFG_SCRATCH_CHECK_EN the same way the RTL build does.
module tb_avalon_cfg_master;

`ifdef AVCFG_SCRATCH_CHECK_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] cfg_numpkts = '0;
    logic [7:0] cfg_pktlength = '0;
    logic [7:0] cfg_payload = '0;
    logic [7:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata = '0;
    logic       waitrequest;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    avalon_cfg_master #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .RD_LAT      (1),
        .TIMEOUT     (64),
        .EXP_VERSION (8'h12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .cfg_numpkts   (cfg_numpkts),
        .cfg_pktlength (cfg_pktlength),
        .cfg_payload   (cfg_payload),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // Slave model: stall_n waitrequest cycles per request, or forever
    // on hang_addr; read data appears one cycle after acceptance.
    int         stall_n = 0;
    int         ws_cnt = 0;
    bit         hang_en = 1'b0;
    logic [7:0] hang_addr = '0;
    logic [7:0] ver_val = 8'h12;
    logic [7:0] scr_val = 8'hA5;

    assign waitrequest = (read || write) &&
        ((hang_en && address == hang_addr) || ws_cnt < stall_n);

    always @(posedge clk) begin
        if (!(read || write)) begin
            ws_cnt <= 0;
        end else if (waitrequest) begin
            ws_cnt <= ws_cnt + 1;
        end else begin
            ws_cnt <= 0;
            if (read)
                readdata <= (address == 8'd5) ? ver_val :
                            (address == 8'd6) ? scr_val : 8'h00;
        end
    end

    typedef struct {
        bit         rd;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t sb_q[$];

    int         done_cnt = 0;
    logic       p_req = 1'b0;
    logic       p_wait = 1'b0;
    logic [7:0] p_addr = '0;
    logic [7:0] p_wd = '0;
    logic       p_rd = 1'b0;
    logic       p_wr = 1'b0;

    always @(negedge clk) begin
        xfer_t e;
        if (done) done_cnt <= done_cnt + 1;
        if (!reset) begin
            if (read && write) begin
                n_checks++;
                $display("FAIL rd_wr_both addr=%0h", address);
            end
            if (p_req && p_wait && (read || write))
                chk("hold_stable", {address, writedata, read, write},
                    {p_addr, p_wd, p_rd, p_wr});
            if (p_req && !p_wait)
                chk("idle_gap", read || write, 0);
            if ((read || write) && !waitrequest) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected got rd=%0b addr=%0h data=%0h exp none",
                             read, address, writedata);
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_kind", read, e.rd);
                    chk("xfer_addr", address, e.addr);
                    if (!e.rd) chk("xfer_data", writedata, e.data);
                end
            end
        end
        p_req  <= !reset && (read || write);
        p_wait <= waitrequest;
        p_addr <= address;
        p_wd   <= writedata;
        p_rd   <= read;
        p_wr   <= write;
    end

    typedef struct {
        logic [7:0] np;
        logic [7:0] pl;
        logic [7:0] py;
        logic [7:0] ver;
        logic [7:0] scr;
        int         stall;
        bit         exp_err;
        logic [1:0] exp_code;
    } vec_t;

    vec_t tbl[6];

    task automatic push_expected(input vec_t v);
        sb_q.push_back('{1'b1, 8'd5, v.ver});
        if (v.ver != 8'h12) return;
        sb_q.push_back('{1'b0, 8'd0, v.np});
        sb_q.push_back('{1'b0, 8'd3, v.pl});
        sb_q.push_back('{1'b0, 8'd4, v.py});
        if (SCR) begin
            sb_q.push_back('{1'b0, 8'd6, 8'hA5});
            sb_q.push_back('{1'b1, 8'd6, v.scr});
            if (v.scr != 8'hA5) return;
        end
        sb_q.push_back('{1'b0, 8'd1, 8'h01});
    endtask

    task automatic do_go(input vec_t v);
        cfg_numpkts   = v.np;
        cfg_pktlength = v.pl;
        cfg_payload   = v.py;
        ver_val       = v.ver;
        scr_val       = v.scr;
        stall_n       = v.stall;
        go            = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("busy_after_go", busy, 1);
        chk("error_cleared", {error, err_code}, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        if (!done) begin
            n_checks++;
            $display("FAIL done_wait got=0 exp=1");
        end
    endtask

    task automatic run_vec(input vec_t v, input bit poke_busy,
                           input bit poke_done);
        int d0;
        d0 = done_cnt;
        push_expected(v);
        do_go(v);
        if (poke_busy) begin
            repeat (3) @(negedge clk);
            cfg_numpkts   = 8'hEE;
            cfg_pktlength = 8'hDD;
            cfg_payload   = 8'hCC;
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            repeat (5) @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        wait_done();
        chk("done_busy_low", busy, 0);
        chk("error", error, v.exp_err);
        chk("err_code", err_code, v.exp_code);
        if (poke_done) begin
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        repeat (12) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("idle_after", busy, 0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t v;
        int   n;
        int   d0;

        tbl[0] = '{8'd3,   8'd64,  8'h5A, 8'h12, 8'hA5, 4, 1'b0, 2'd0};
        tbl[1] = '{8'd1,   8'd2,   8'd3,  8'h13, 8'hA5, 4, 1'b1, 2'd1};
        tbl[2] = '{8'd7,   8'd8,   8'd9,  8'h12, 8'h00, 4, SCR,
                   SCR ? 2'd2 : 2'd0};
        tbl[3] = '{8'hFF,  8'h00,  8'hC3, 8'h12, 8'hA5, 0, 1'b0, 2'd0};
        tbl[4] = '{8'h10,  8'h20,  8'h30, 8'h12, 8'hA5, 1, 1'b0, 2'd0};
        tbl[5] = '{8'h44,  8'h55,  8'h66, 8'h00, 8'hA5, 2, 1'b1, 2'd1};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {address, read, write, writedata, busy, done, error, err_code}, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], i == 0, i < 2);

        // Endless stall on the PKTLENGTH write.
        v = tbl[0];
        v.stall = 0;
        hang_addr = 8'd3;
        hang_en = 1'b1;
        sb_q.push_back('{1'b1, 8'd5, 8'h12});
        sb_q.push_back('{1'b0, 8'd0, v.np});
        do_go(v);
        for (int i = 0; i < 500 && !(write && address == 8'd3); i++)
            @(negedge clk);
        n = 0;
        while (write && address == 8'd3 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_len", n, 64);
        wait_done();
        chk("timeout_error", error, 1);
        chk("timeout_code", err_code, 3);
        chk("timeout_sb", sb_q.size(), 0);
        hang_en = 1'b0;
        repeat (3) @(negedge clk);
        run_vec(tbl[0], 1'b0, 1'b0);

        // Reset while the PAYLOAD write is stalled.
        v = tbl[4];
        hang_addr = 8'd4;
        hang_en = 1'b1;
        sb_q.push_back('{1'b1, 8'd5, 8'h12});
        sb_q.push_back('{1'b0, 8'd0, v.np});
        sb_q.push_back('{1'b0, 8'd3, v.pl});
        do_go(v);
        for (int i = 0; i < 500 && !(write && address == 8'd4); i++)
            @(negedge clk);
        chk("payload_stalled", {write, address}, {1'b1, 8'd4});
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_outputs",
            {address, read, write, writedata, busy, done, error, err_code}, 0);
        reset = 1'b0;
        hang_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_done_on_reset", done_cnt - d0, 0);
        chk("reset_sb", sb_q.size(), 0);
        run_vec(tbl[3], 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/avalon_cfg_master.md
Name: avalon_cfg_master

Overview:
- Avalon-MM master that sits directly upstream of the 8-bit register slave and programs it.
- On a single `go` pulse it runs a fixed transaction sequence:
  - check VERSION;
  - load NUMPKTS, PKTLENGTH and PAYLOAD;
  - optionally run a SCRATCH write/readback sanity check;
  - write START.
- Reports busy/done/error to the local controller.
- A watchdog aborts the sequence if `waitrequest` stalls.

Parameters:
- DATA_W, 8, Avalon data width.
- ADDR_W, 8, Avalon address width.
- RD_LAT, 1, cycles from read acceptance to valid `readdata` (legal values 0..3).
- TIMEOUT, 64, maximum consecutive `waitrequest` cycles per transaction before abort.
- EXP_VERSION, 8'h12, required VERSION register value.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- go  input  1  start pulse; ignored unless idle.
- cfg_numpkts  input  DATA_W  value for NUMPKTS; sampled on accepted `go`.
- cfg_pktlength  input  DATA_W  value for PKTLENGTH; sampled on accepted `go`.
- cfg_payload  input  DATA_W  value for PAYLOAD; sampled on accepted `go`.
- address  output  ADDR_W  Avalon address.
- read  output  1  Avalon read request.
- write  output  1  Avalon write request.
- writedata  output  DATA_W  Avalon write data.
- readdata  input  DATA_W  Avalon read data.
- waitrequest  input  1  Avalon stall.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence end (success or error).
- error  output  1  sticky error flag; cleared by next accepted `go`.
- err_code  output  2  0 none, 1 version mismatch, 2 scratch mismatch, 3 timeout.

Behaviour:
- One clock domain, clk. Reset is synchronous, active-high, on port `reset`.
- Reset values:
  - address=0, read=0, write=0, writedata=0;
  - busy=0, done=0, error=0, err_code=0;
  - state=IDLE; timeout counter=0.
- Reset mid-sequence drops read/write on the next edge, with no completion pulse.
- All Avalon outputs are registered.
- Handshake:
  - A request (read or write) is accepted on a clk edge where it is asserted and `waitrequest`=0.
  - Address, writedata, read and write are held stable while `waitrequest`=1.
  - Never assert read and write together.
  - Deassert in the cycle after acceptance; at least one idle cycle between transactions.
- Read data: `readdata` is sampled RD_LAT cycles after the accepting edge. RD_LAT=0 means sampling on the accepting edge itself.
- State machine:
  - IDLE -> RD_VER on `go`. On that edge: latch cfg_* inputs, busy=1, error=0, err_code=0.
  - RD_VER: read addr 5, then RD_WAIT.
    - readdata != EXP_VERSION -> ERR, code 1.
    - Otherwise -> WR_NUMPKTS.
  - WR_NUMPKTS: addr 0, data cfg_numpkts -> WR_PKTLEN.
  - WR_PKTLEN: addr 3, data cfg_pktlength -> WR_PAYLOAD.
  - WR_PAYLOAD: addr 4, data cfg_payload -> WR_SCRATCH (feature on) or WR_START (feature off).
  - WR_SCRATCH: addr 6, data 8'hA5 -> RD_SCRATCH.
  - RD_SCRATCH: read addr 6, then RD_WAIT.
    - readdata != 8'hA5 -> ERR, code 2.
    - Otherwise -> WR_START.
  - WR_START: addr 1, data 8'h01 -> FINISH.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: error=1, done=1 for one cycle, busy=0 -> IDLE.
- Timeout:
  - Counter clears when each request is issued and increments each cycle the request is stalled.
  - Reaching TIMEOUT: drop the request next cycle, go to ERR with code 3.
  - The count is TIMEOUT stalled cycles exactly; acceptance on the TIMEOUT-th cycle still counts as success.
- `go` while busy is ignored, with no queueing. `go` in the same cycle as FINISH/ERR is also ignored.
- Reads and writes to addr 2 (STOP), addr 7 and addr 5 writes are never issued.
- err_code holds its value until the next accepted `go` or reset.

Optional Feature:
- Macro: AVCFG_SCRATCH_CHECK_EN.
- Defined: WR_SCRATCH/RD_SCRATCH are included; a sequence is 7 transactions (2 reads, 5 writes).
- Undefined: WR_PAYLOAD -> WR_START directly; a sequence is 5 transactions; err_code 2 is never produced.

Decomposition:
- Package avcfg_pkg holds:
  - state enum;
  - register address localparams (NUMPKTS=0, START=1, STOP=2, PKTLENGTH=3, PAYLOAD=4, VERSION=5, SCRATCH=6);
  - err_code enum;
  - SCRATCH_PATTERN=8'hA5.
- One sub-module, avcfg_watchdog: parameterised TIMEOUT counter with clear/enable inputs and an expired output.

Test Plan:
- Nominal run, feature on, slave 4-cycle waitrequest, VERSION=8'h12, cfg=(3,64,8'h5A):
  - writes observed in order: addr0=3, addr3=64, addr4=5A, addr6=A5, addr1=01;
  - done pulses once; error=0; busy high from go+1 to done.
- VERSION read returns 8'h13: no writes issued; done pulse; error=1, err_code=1.
- Scratch readback returns 8'h00 (feature on): error=1, err_code=2; addr1 is never written.
- Timeout: waitrequest held high indefinitely on the WR_PKTLEN write:
  - write drops after exactly 64 stalled cycles;
  - err_code=3; next `go` clears error and the sequence restarts.
- Protocol stability: `go` pulsed while busy and at the FINISH cycle is ignored. Assertions check:
  - address/writedata stable under waitrequest;
  - read and write never high together;
  - one idle cycle between transactions.
- Reset mid-sequence: synchronous reset asserted during the WR_PAYLOAD stall:
  - all outputs reach reset values on the next edge;
  - no done pulse;
  - a fresh `go` completes normally.
